// File: rtl/fifo_pkg.sv
// Shared sizing for the FIFO write-side packer: default widths and the
// beats-per-word ratio helper.
package fifo_pkg;

  localparam int FIFO_DATA_W = 128;
  localparam int FIFO_IN_W   = 32;

  function automatic int packRatio(input int dataW, input int inW);
    return dataW / inW;
  endfunction

  function automatic bit packCfgOk(input int dataW, input int inW);
    return (inW > 0) && (dataW % inW == 0) && (dataW / inW >= 2);
  endfunction

endpackage

// File: rtl/fifo_wr_packer_if.sv
// Beat stream in, FIFO write port out; the packer sits on the slave side.
interface fifo_wr_packer_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int IN_W   = FIFO_IN_W
);

  logic              in_valid;
  logic [IN_W-1:0]   in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;

  modport master (
    output in_valid, in_data, in_last, full,
    input  in_ready, wr_en, wr_data
  );

  modport slave (
    input  in_valid, in_data, in_last, full,
    output in_ready, wr_en, wr_data
  );

endinterface

// File: rtl/fifo_wr_hold.sv
// Single-entry holding register between the packer and the FIFO write port;
// a word is released in whichever cycle the FIFO is not full.
module fifo_wr_hold
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              hold_vld
);

  logic              hold_vld_q;
  logic              hold_vld_d;
  logic [DATA_W-1:0] hold_data_q;
  logic [DATA_W-1:0] hold_data_d;
  logic              wrFire;

  assign wrFire = hold_vld_q & ~full;

  // A load in the same cycle as a write keeps the entry valid with the new word.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (load) begin
      hold_vld_d  = 1'b1;
      hold_data_d = data;
    end else if (wrFire) begin
      hold_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign wr_en    = wrFire;
  assign wr_data  = hold_data_q;
  assign hold_vld = hold_vld_q;

endmodule

// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow beats per FIFO word (lane 0 first), zero-pads on in_last,
// and hands completed words to a single-entry hold stage.
module fifo_wr_packer
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int IN_W   = FIFO_IN_W
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_wr_packer_if.slave      bus,
  output logic                 busy,
  output logic [31:0]          word_cnt
);

  localparam int RATIO  = packRatio(DATA_W, IN_W);
  localparam int LANE_W = $clog2(RATIO);

  if (!packCfgOk(DATA_W, IN_W)) begin : g_cfgCheck
    $error("fifo_wr_packer: DATA_W must be a multiple of IN_W with a ratio of at least 2");
  end

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [LANE_W-1:0] lane_q;
  logic [LANE_W-1:0] lane_d;
  logic [31:0]       word_cnt_q;
  logic [31:0]       word_cnt_d;
  logic [DATA_W-1:0] nextWord;
  logic              lastLane;
  logic              closingBeat;
  logic              inFire;
  logic              closeWord;
  logic              wrFire;
  logic              holdVld;
  logic [DATA_W-1:0] holdData;

  assign lastLane    = (lane_q == LANE_W'(RATIO - 1));
  assign closingBeat = lastLane | bus.in_last;
  assign bus.in_ready = ~closingBeat | ~holdVld | wrFire;
  assign inFire      = bus.in_valid & bus.in_ready;
  assign closeWord   = inFire & closingBeat;

  // Lanes below the current one come from the accumulator, lanes above are zero.
  always_comb begin
    nextWord = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (i == int'(lane_q)) begin
        nextWord[i*IN_W +: IN_W] = bus.in_data;
      end else if (i < int'(lane_q)) begin
        nextWord[i*IN_W +: IN_W] = acc_q[i*IN_W +: IN_W];
      end
    end
  end

  always_comb begin
    acc_d      = acc_q;
    lane_d     = lane_q;
    word_cnt_d = word_cnt_q;
    if (closeWord) begin
      acc_d  = '0;
      lane_d = '0;
    end else if (inFire) begin
      acc_d  = nextWord;
      lane_d = lane_q + LANE_W'(1);
    end
    if (wrFire) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      lane_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      lane_q     <= lane_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  fifo_wr_hold #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (closeWord),
    .data     (nextWord),
    .full     (bus.full),
    .wr_en    (wrFire),
    .wr_data  (holdData),
    .hold_vld (holdVld)
  );

  assign bus.wr_en   = wrFire;
  assign bus.wr_data = holdData;
  assign busy        = (lane_q != '0) | holdVld;
  assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer: packing, padding, backpressure, streaming
// and mid-operation reset, each scenario with hand-computed expectations.
module tb_fifo_wr_packer;
  import fifo_pkg::*;

  localparam int DATA_W = FIFO_DATA_W;
  localparam int IN_W   = FIFO_IN_W;

  logic        clk;
  logic        reset;
  logic        busy;
  logic [31:0] word_cnt;
  int          checks;
  int          errors;

  fifo_wr_packer_if #(.DATA_W(DATA_W), .IN_W(IN_W)) bus ();

  fifo_wr_packer #(
    .DATA_W (DATA_W),
    .IN_W   (IN_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one beat, waits (bounded) for acceptance, returns at edge+1.
  task automatic sendBeat(input logic [31:0] d, input logic last);
    int waitCycles;
    waitCycles = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    #1;
    while (bus.in_ready !== 1'b1 && waitCycles < 50) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (waitCycles >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_accept_timeout data=%h in_ready=%b required 1", d, bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.full     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
    checks++;
    if (bus.wr_data !== '0) begin errors++; $display("[TB] FAIL reset_wr_data got=%h exp=0", bus.wr_data); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (word_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
  endtask

  task automatic test_full_word();
    sendBeat(32'h11111111, 1'b0);
    sendBeat(32'h22222222, 1'b0);
    sendBeat(32'h33333333, 1'b0);
    checks++;
    if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL early_wr_en got=%b exp=0", bus.wr_en); end
    sendBeat(32'h44444444, 1'b0);
    checks++;
    if (bus.wr_en !== 1'b1) begin errors++; $display("[TB] FAIL full_word_wr_en got=%b exp=1", bus.wr_en); end
    checks++;
    if (bus.wr_data !== 128'h44444444_33333333_22222222_11111111) begin
      errors++; $display("[TB] FAIL full_word_data got=%h exp=%h", bus.wr_data, 128'h44444444_33333333_22222222_11111111);
    end
    idleCycle();
    checks++;
    if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL full_word_single_pulse got=%b exp=0", bus.wr_en); end
    checks++;
    if (word_cnt !== 32'd1) begin errors++; $display("[TB] FAIL full_word_cnt got=%0d exp=1", word_cnt); end
  endtask

  task automatic test_partial();
    sendBeat(32'h0000000A, 1'b0);
    sendBeat(32'h0000000B, 1'b0);
    sendBeat(32'h0000000C, 1'b1);
    checks++;
    if (bus.wr_en !== 1'b1) begin errors++; $display("[TB] FAIL partial_wr_en got=%b exp=1", bus.wr_en); end
    checks++;
    if (bus.wr_data !== 128'h00000000_0000000C_0000000B_0000000A) begin
      errors++; $display("[TB] FAIL partial_data got=%h exp=%h", bus.wr_data, 128'h00000000_0000000C_0000000B_0000000A);
    end
    sendBeat(32'h0000000D, 1'b1);
    checks++;
    if (bus.wr_data !== 128'h00000000_00000000_00000000_0000000D || bus.wr_en !== 1'b1) begin
      errors++; $display("[TB] FAIL partial_next_lane0 got=%h en=%b exp=%h en=1", bus.wr_data, bus.wr_en, 128'h0000000D);
    end
    idleCycle();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL partial_busy got=%b exp=0", busy); end
    checks++;
    if (word_cnt !== 32'd3) begin errors++; $display("[TB] FAIL partial_word_cnt got=%0d exp=3", word_cnt); end
  endtask

  task automatic test_backpressure();
    bus.full = 1'b1;
    for (int i = 1; i <= 4; i++) sendBeat(32'h100 + 32'(i), 1'b0);
    checks++;
    if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_wr_en_while_full got=%b exp=0", bus.wr_en); end
    for (int i = 5; i <= 7; i++) sendBeat(32'h100 + 32'(i), 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h108;
    bus.in_last  = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_beat8 got=%b exp=0", bus.in_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_stall_hold ready=%b wr_en=%b busy=%b exp ready=0 wr_en=0 busy=1", bus.in_ready, bus.wr_en, busy);
    end
    bus.full = 1'b0;
    #1;
    checks++;
    if (bus.wr_en !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_release wr_en=%b ready=%b exp 1 1", bus.wr_en, bus.in_ready);
    end
    checks++;
    if (bus.wr_data !== 128'h00000104_00000103_00000102_00000101) begin
      errors++; $display("[TB] FAIL bp_first_word got=%h exp=%h", bus.wr_data, 128'h00000104_00000103_00000102_00000101);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_data !== 128'h00000108_00000107_00000106_00000105) begin
      errors++; $display("[TB] FAIL bp_second_word en=%b got=%h exp=%h", bus.wr_en, bus.wr_data, 128'h00000108_00000107_00000106_00000105);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_drained wr_en=%b busy=%b exp 0 0", bus.wr_en, busy);
    end
    checks++;
    if (word_cnt !== 32'd5) begin errors++; $display("[TB] FAIL bp_word_cnt got=%0d exp=5", word_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] expWord;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h1000 + 32'(i);
      bus.in_last  = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready beat=%0d got=%b exp=1", i, bus.in_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (bus.wr_en !== ((i % 4) == 3)) begin
        errors++; $display("[TB] FAIL stream_wr_en beat=%0d got=%b exp=%b", i, bus.wr_en, (i % 4) == 3);
      end
      if ((i % 4) == 3) begin
        expWord = {32'h1000 + 32'(i), 32'h1000 + 32'(i - 1), 32'h1000 + 32'(i - 2), 32'h1000 + 32'(i - 3)};
        checks++;
        if (bus.wr_data !== expWord) begin
          errors++; $display("[TB] FAIL stream_data beat=%0d got=%h exp=%h", i, bus.wr_data, expWord);
        end
      end
    end
    idleCycle();
    checks++;
    if (word_cnt !== 32'd9) begin errors++; $display("[TB] FAIL stream_word_cnt got=%0d exp=9", word_cnt); end
  endtask

  task automatic test_single_beat();
    sendBeat(32'hDEADBEEF, 1'b1);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_data !== 128'h00000000_00000000_00000000_DEADBEEF) begin
      errors++; $display("[TB] FAIL single_beat en=%b got=%h exp=%h", bus.wr_en, bus.wr_data, 128'hDEADBEEF);
    end
    idleCycle();
    checks++;
    if (word_cnt !== 32'd10 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL single_beat_after cnt=%0d busy=%b exp cnt=10 busy=0", word_cnt, busy);
    end
  endtask

  task automatic test_reset_midop();
    bus.full = 1'b1;
    for (int i = 0; i < 6; i++) sendBeat(32'h5000 + 32'(i), 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midop_busy_before got=%b exp=1", busy); end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    bus.full = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || word_cnt !== 32'd0 || bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL midop_after_reset busy=%b cnt=%0d ready=%b exp 0 0 1", busy, word_cnt, bus.in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL midop_no_write cycle=%0d got=%b exp=0", i, bus.wr_en); end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_word();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_single_beat();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
